// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, controller states, ALU codes.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LD  = 4'h5;
    localparam logic [3:0] OP_ST  = 4'h6;
    localparam logic [3:0] OP_BEQ = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] op);
        logic [1:0] code;
        code = ALU_ADD;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control/handshake bundle between the CPU controller and its datapath and memory.
interface cpu_ctrl_fsm_if #(
    parameter int unsigned AW = 8
);
    logic [15:0]   ir;
    logic          zero_flag;
    logic          mem_ready;
    logic          ir_load;
    logic          inc_PC;
    logic          pc_src;
    logic [AW-1:0] next_addr;
    logic          halt;
    logic          mem_read;
    logic          mem_write;
    logic          addr_sel;
    logic          reg_write;
    logic          wb_sel;
    logic [1:0]    alu_op;
    logic          illegal;
    logic          bus_err;

    modport master (
        input  ir, zero_flag, mem_ready,
        output ir_load, inc_PC, pc_src, next_addr, halt, mem_read, mem_write,
               addr_sel, reg_write, wb_sel, alu_op, illegal, bus_err
    );

    modport slave (
        output ir, zero_flag, mem_ready,
        input  ir_load, inc_PC, pc_src, next_addr, halt, mem_read, mem_write,
               addr_sel, reg_write, wb_sel, alu_op, illegal, bus_err
    );
endinterface

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// Counts stalled cycles of a memory (or I/O) access and flags a timeout at the limit.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] wait_cnt;

    // Ready on the limit cycle is a normal completion, so it masks the timeout.
    assign timeout = active && !ready && (wait_cnt == CW'(LIMIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!active || ready || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/writeback and drives
// PC, IR, memory and register-file control pins.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned OPW        = 4,
    parameter int unsigned AW         = 8,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    cpu_ctrl_fsm_if.master  bus
);
    state_t         state;
    logic           illegal_q;
    logic           bus_err_q;
    logic           mem_phase;
    logic           timeout;
    logic [OPW-1:0] opcode;
    logic [3:0]     op;

    assign opcode    = bus.ir[15 -: OPW];
    assign op        = 4'(opcode);
    assign mem_phase = (state == S_FETCH) || (state == S_MEM);

    mem_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (mem_phase),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (is_alu_op(op)) begin
                        state <= S_WB;
                    end else begin
                        case (op)
                            OP_LD, OP_ST:          state <= S_MEM;
                            OP_NOP, OP_BEQ, OP_JMP: state <= S_FETCH;
                            OP_HLT:                state <= S_HALT;
                            default: begin
                                illegal_q <= 1'b1;
                                state     <= S_HALT;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        state <= (op == OP_LD) ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.next_addr = bus.ir[AW-1:0];
    assign bus.illegal   = illegal_q;
    assign bus.bus_err   = bus_err_q;

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        bus.ir_load   = 1'b0;
        bus.inc_PC    = 1'b0;
        bus.pc_src    = 1'b0;
        bus.halt      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_sel    = 1'b0;
        bus.alu_op    = ALU_ADD;
        unique case (state)
            S_IDLE: bus.halt = 1'b1;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_load  = bus.mem_ready;
                bus.inc_PC   = bus.mem_ready;
            end
            S_DECODE: ;
            S_EXEC: begin
                if (is_alu_op(op)) bus.alu_op = alu_code(op);
                if (op == OP_BEQ)  bus.pc_src = bus.zero_flag;
                if (op == OP_JMP)  bus.pc_src = 1'b1;
            end
            S_MEM: begin
                bus.addr_sel  = 1'b1;
                bus.mem_read  = (op == OP_LD);
                bus.mem_write = (op == OP_ST);
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = (op == OP_LD);
            end
            S_HALT:  bus.halt = 1'b1;
            default: bus.halt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed and random instructions checked per cycle
// against an instruction-level expansion of the expected control-pin trace.
module tb_cpu_ctrl_fsm;
    localparam int unsigned LIMIT = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;

    cpu_ctrl_fsm_if #(.AW(8)) bus ();

    cpu_ctrl_fsm #(
        .OPW        (4),
        .AW         (8),
        .WAIT_LIMIT (LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_load;
        logic       inc_pc;
        logic       pc_src;
        logic       halt;
        logic       mem_read;
        logic       mem_write;
        logic       addr_sel;
        logic       reg_write;
        logic       wb_sel;
        logic [1:0] alu_op;
        logic       illegal;
        logic       bus_err;
        logic [7:0] next_addr;
    } out_t;

    // rdy: 0/1 drives mem_ready, 2 means mem_ready is don't-care and gets randomised
    typedef struct {
        int   rdy;
        out_t exp;
    } step_t;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    logic [15:0] cur_ir = 16'h0000;

    function automatic out_t sample();
        out_t s;
        s.ir_load   = bus.ir_load;
        s.inc_pc    = bus.inc_PC;
        s.pc_src    = bus.pc_src;
        s.halt      = bus.halt;
        s.mem_read  = bus.mem_read;
        s.mem_write = bus.mem_write;
        s.addr_sel  = bus.addr_sel;
        s.reg_write = bus.reg_write;
        s.wb_sel    = bus.wb_sel;
        s.alu_op    = bus.alu_op;
        s.illegal   = bus.illegal;
        s.bus_err   = bus.bus_err;
        s.next_addr = bus.next_addr;
        return s;
    endfunction

    function automatic out_t base(input logic [15:0] iv);
        out_t b;
        b = '0;
        b.next_addr = iv[7:0];
        return b;
    endfunction

    task automatic check(input string tag, input out_t obs, input out_t exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        out_t e;
        e = base(cur_ir);
        e.halt = 1'b1;
        check(tag, sample(), e);
    endtask

    task automatic reset_and_start();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        bus.mem_ready = 1'b0;
        #1 expect_idle("rst_assert");
        @(negedge clk);
        #1 expect_idle("rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        #1 expect_idle("idle_start");
    endtask

    // Expand one instruction into its expected cycle trace, then drive and check it.
    task automatic run_instr(input logic [15:0] iv, input logic zf, input int unsigned fs,
                             input int unsigned ms, input int unsigned cut);
        step_t q[$];
        step_t s;
        logic [3:0] op;
        op = iv[15:12];
        for (int unsigned i = 0; i < fs; i++) begin
            s.rdy = 0; s.exp = base(iv); s.exp.mem_read = 1'b1; q.push_back(s);
        end
        s.rdy = 1; s.exp = base(iv);
        s.exp.mem_read = 1'b1; s.exp.ir_load = 1'b1; s.exp.inc_pc = 1'b1;
        q.push_back(s);
        s.rdy = 2; s.exp = base(iv); q.push_back(s);
        s.rdy = 2; s.exp = base(iv);
        if (op >= 4'd1 && op <= 4'd4) s.exp.alu_op = 2'(op - 4'd1);
        if (op == 4'd7) s.exp.pc_src = zf;
        if (op == 4'd8) s.exp.pc_src = 1'b1;
        q.push_back(s);
        if (op == 4'd5 || op == 4'd6) begin
            for (int unsigned i = 0; i <= ms; i++) begin
                s.rdy = (i == ms) ? 1 : 0;
                s.exp = base(iv);
                s.exp.addr_sel  = 1'b1;
                s.exp.mem_read  = (op == 4'd5);
                s.exp.mem_write = (op == 4'd6);
                q.push_back(s);
            end
        end
        if (op >= 4'd1 && op <= 4'd5) begin
            s.rdy = 2; s.exp = base(iv);
            s.exp.reg_write = 1'b1; s.exp.wb_sel = (op == 4'd5);
            q.push_back(s);
        end
        for (int unsigned i = 0; i < q.size(); i++) begin
            if (cut != 0 && i >= cut) break;
            @(negedge clk);
            start = 1'b0;
            cur_ir = iv;
            bus.ir = iv;
            bus.zero_flag = zf;
            bus.mem_ready = (q[i].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(q[i].rdy);
            #1 check($sformatf("ir%h_cyc%0d", iv, i), sample(), q[i].exp);
        end
    endtask

    task automatic expect_halt(input int unsigned n, input logic ill, input logic be, input string tag);
        out_t e;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b1;
            bus.mem_ready = 1'($urandom_range(0, 1));
            e = base(cur_ir);
            e.halt = 1'b1;
            e.illegal = ill;
            e.bus_err = be;
            #1 check($sformatf("%s_%0d", tag, i), sample(), e);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t e;
        logic [15:0] iv;
        bus.ir = 16'h0000;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;

        reset_and_start();
        run_instr(16'h1203, 1'b0, 0, 0, 0);
        run_instr(16'h5140, 1'b0, 0, 3, 0);
        run_instr(16'h7022, 1'b1, 0, 0, 0);
        run_instr(16'h7022, 1'b0, 1, 0, 0);
        run_instr(16'h8055, 1'b0, 0, 0, 0);
        run_instr(16'h0000, 1'b1, 2, 0, 0);
        run_instr(16'h6033, 1'b0, 0, 2, 0);
        run_instr(16'h4abc, 1'b0, 1, 0, 0);
        run_instr(16'h2abc, 1'b0, LIMIT, 0, 0);
        run_instr(16'h6011, 1'b0, 0, LIMIT, 0);
        run_instr(16'h5099, 1'b1, LIMIT, LIMIT, 0);

        for (int unsigned n = 0; n < 40; n++) begin
            iv = {4'($urandom_range(0, 8)), 12'($urandom)};
            run_instr(iv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        run_instr(16'hF000, 1'b0, 0, 0, 0);
        expect_halt(20, 1'b0, 1'b0, "hlt");

        reset_and_start();
        run_instr(16'hA000, 1'b0, 0, 0, 0);
        expect_halt(3, 1'b1, 1'b0, "illegal");

        reset_and_start();
        for (int unsigned k = 0; k <= LIMIT; k++) begin
            @(negedge clk);
            start = 1'b0;
            bus.mem_ready = 1'b0;
            e = base(cur_ir);
            e.mem_read = 1'b1;
            #1 check($sformatf("fetch_wait_%0d", k), sample(), e);
        end
        expect_halt(3, 1'b0, 1'b1, "timeout");

        reset_and_start();
        run_instr(16'h5077, 1'b0, 0, 5, 5);
        @(negedge clk);
        reset_n = 1'b0;
        #1 expect_idle("rst_mid_mem");
        @(negedge clk);
        #1 expect_idle("rst_mid_mem_hold");
        reset_n = 1'b1;
        @(negedge clk);
        #1 expect_idle("idle_no_start");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
